// File: rtl/minrv32_mem_pkg.sv
// ============================================================================
// Module   : minrv32_mem_pkg
// Purpose  : Shared types and widths for the minrv32 memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package minrv32_mem_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = 4;

  typedef logic [STRB_W-1:0] wstrb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/minrv32_mem_array.sv
// ============================================================================
// Module   : minrv32_mem_array
// Purpose  : Word RAM with byte-lane write enables and asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module minrv32_mem_array
    import minrv32_mem_pkg::*;
#(
    parameter int  MEM_WORDS = 1024,
    parameter      INIT_FILE = "",
    localparam int AW        = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic [AW-1:0]     addr,
    input  wstrb_t            we,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] r_mem [0:MEM_WORDS-1];

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) r_mem[i] = '0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (we[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = r_mem[addr];

endmodule

`default_nettype wire

// File: rtl/minrv32_mem_responder.sv
// ============================================================================
// Module   : minrv32_mem_responder
// Purpose  : minrv32 native-bus memory slave with latency, error flag and counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module minrv32_mem_responder
  import minrv32_mem_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 0,
  parameter              INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  input  wstrb_t            mem_wstrb,
  input  logic              stall,
  output logic              mem_ready,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              err,
  output logic [WORD_W-1:0] cnt_fetch,
  output logic [WORD_W-1:0] cnt_rd,
  output logic [WORD_W-1:0] cnt_wr
);

  localparam int AW = $clog2(MEM_WORDS);

  state_t            r_state;
  state_t            w_next;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  wstrb_t            r_wstrb;
  logic              r_instr;
  logic [3:0]        r_wait;
  logic              r_err;
  logic [WORD_W-1:0] r_cnt_fetch;
  logic [WORD_W-1:0] r_cnt_rd;
  logic [WORD_W-1:0] r_cnt_wr;

  logic [WORD_W-1:0] w_off;
  logic              w_in_range;
  logic              w_misalign;
  logic              w_is_wr;
  logic [AW-1:0]     w_idx;
  wstrb_t            w_we;
  logic [WORD_W-1:0] w_ram_rdata;

  // BASE_ADDR is aligned to the RAM size, so the offset's low bits equal addr[1:0].
  assign w_off      = r_addr - BASE_ADDR;
  assign w_in_range = (w_off[WORD_W-1:AW+2] == '0);
  assign w_misalign = |w_off[1:0];
  assign w_idx      = w_off[AW+1:2];
  assign w_is_wr    = !r_instr && (|r_wstrb);
  assign w_we       = {STRB_W{(r_state == RESP) && resetn && w_is_wr && w_in_range}} & r_wstrb;

  minrv32_mem_array #(
    .MEM_WORDS (MEM_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk   (clk),
    .addr  (w_idx),
    .we    (w_we),
    .wdata (r_wdata),
    .rdata (w_ram_rdata)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (mem_valid) w_next = WAIT;
      WAIT: begin
        if (!mem_valid)                  w_next = IDLE;
        else if (!stall && r_wait == '0) w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_instr     <= 1'b0;
      r_wait      <= '0;
      r_err       <= 1'b0;
      r_cnt_fetch <= '0;
      r_cnt_rd    <= '0;
      r_cnt_wr    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_valid) begin
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_instr <= mem_instr;
            r_wait  <= 4'(LATENCY);
          end
        end
        WAIT: begin
          if (!mem_valid) begin
            r_err <= 1'b1;
          end else if (!stall) begin
            if (r_wait != '0)                    r_wait <= r_wait - 4'd1;
            else if (!w_in_range || w_misalign)  r_err  <= 1'b1;
          end
        end
        RESP: begin
          if (r_instr) begin
            if (r_cnt_fetch != '1) r_cnt_fetch <= r_cnt_fetch + 1'b1;
          end else if (|r_wstrb) begin
            if (r_cnt_wr != '1) r_cnt_wr <= r_cnt_wr + 1'b1;
          end else begin
            if (r_cnt_rd != '1) r_cnt_rd <= r_cnt_rd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_ready = (r_state == RESP);
  assign mem_rdata = (mem_ready && !w_is_wr && w_in_range) ? w_ram_rdata : '0;
  assign err       = r_err;
  assign cnt_fetch = r_cnt_fetch;
  assign cnt_rd    = r_cnt_rd;
  assign cnt_wr    = r_cnt_wr;

endmodule

`default_nettype wire

// File: tb/tb_minrv32_mem_responder.sv
// ============================================================================
// Module   : tb_minrv32_mem_responder
// Purpose  : Directed scoreboard bench for two responders (LATENCY 0 and 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_minrv32_mem_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        v0 = 1'b0, v3 = 1'b0;
  logic        instr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        st0 = 1'b0, st3 = 1'b0;

  logic        ready0, ready3, err0, err3;
  logic [31:0] rdata0, rdata3;
  logic [31:0] cf0, cr0, cw0, cf3, cr3, cw3;

  typedef struct {
    logic [31:0] rd;
    int          cyc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  minrv32_mem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .resetn(resetn), .mem_valid(v0), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .stall(st0), .mem_ready(ready0), .mem_rdata(rdata0),
    .err(err0), .cnt_fetch(cf0), .cnt_rd(cr0), .cnt_wr(cw0)
  );

  minrv32_mem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3), .INIT_FILE("")) u_dut3 (
    .clk(clk), .resetn(resetn), .mem_valid(v3), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .stall(st3), .mem_ready(ready3), .mem_rdata(rdata3),
    .err(err3), .cnt_fetch(cf3), .cnt_rd(cr3), .cnt_wr(cw3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request; a non-abandoned transfer pops its expectation on mem_ready.
  task automatic xfer(input bit d3, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input bit ins, input int n_stall, input bit abandon);
    int   cyc;
    bit   got;
    exp_t e;
    logic rdy;
    @(negedge clk);
    addr = a; wdata = wd; wstrb = s; instr = ins;
    if (d3) v3 = 1'b1; else v0 = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (abandon ? (cyc < 8) : (!got && cyc < 40)) begin
      @(posedge clk); #1;
      cyc++;
      if (abandon && cyc == 1) begin v0 = 1'b0; v3 = 1'b0; end
      if (cyc == 1 && n_stall > 0) st3 = 1'b1;
      if (cyc == 1 + n_stall)      st3 = 1'b0;
      rdy = d3 ? ready3 : ready0;
      if (rdy && !got) begin
        got = 1'b1;
        v0 = 1'b0; v3 = 1'b0;
        if (!abandon && q.size() > 0) begin
          e = q.pop_front();
          chk("rdata", d3 ? rdata3 : rdata0, e.rd);
          chk("ready_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
    v0 = 1'b0; v3 = 1'b0; st3 = 1'b0;
    chk(abandon ? "no_ready" : "ready_seen", {31'd0, got}, {31'd0, !abandon});
    if (!abandon) begin
      @(posedge clk); #1;
      chk("single_pulse", {31'd0, d3 ? ready3 : ready0}, 32'd0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready0}, 32'd0);
    chk("rst_rdata", rdata0, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    chk("rst_cnt_fetch", cf0, 32'd0);
    chk("rst_cnt_rd", cr0, 32'd0);
    chk("rst_cnt_wr", cw0, 32'd0);
    @(negedge clk); resetn = 1'b1;

    // Preload RAM of the zero-latency responder
    q.push_back('{32'h0, 2});
    xfer(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, 1'b0);
    q.push_back('{32'h0, 2});
    xfer(1'b0, 32'h20, 32'hAAAAAAAA, 4'hF, 1'b0, 0, 1'b0);
    chk("pre_cnt_wr", cw0, 32'd2);

    // Latency-3 responder: write, stalled read, abandoned request
    q.push_back('{32'h0, 5});
    xfer(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0, 0, 1'b0);
    q.push_back('{32'hCAFEF00D, 7});
    xfer(1'b1, 32'h40, 32'h0, 4'h0, 1'b0, 2, 1'b0);
    chk("l3_cnt_rd", cr3, 32'd1);
    chk("l3_cnt_wr", cw3, 32'd1);
    chk("l3_err_clean", {31'd0, err3}, 32'd0);
    xfer(1'b1, 32'h40, 32'h0, 4'h0, 1'b0, 0, 1'b1);
    chk("proto_err", {31'd0, err3}, 32'd1);
    chk("proto_cnt_rd", cr3, 32'd1);

    pulse_reset();
    #1;
    chk("rst2_err3", {31'd0, err3}, 32'd0);
    chk("rst2_cnt_rd3", cr3, 32'd0);
    chk("rst2_cnt_wr3", cw3, 32'd0);
    chk("rst2_cnt_wr0", cw0, 32'd0);

    // Zero-latency responder after reset; RAM contents must survive
    q.push_back('{32'hDEADBEEF, 2});
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 0, 1'b0);
    chk("rd_cnt_rd", cr0, 32'd1);
    q.push_back('{32'h0, 2});
    xfer(1'b0, 32'h20, 32'h11223344, 4'b0101, 1'b0, 0, 1'b0);
    q.push_back('{32'hAA22AA44, 2});
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 0, 1'b0);
    chk("strb_cnt_wr", cw0, 32'd1);
    chk("strb_cnt_rd", cr0, 32'd2);
    chk("good_err", {31'd0, err0}, 32'd0);

    // Fetch just past the top of RAM
    q.push_back('{32'h0, 2});
    xfer(1'b0, 32'h1000, 32'h0, 4'h0, 1'b1, 0, 1'b0);
    chk("oob_err", {31'd0, err0}, 32'd1);
    chk("oob_cnt_fetch", cf0, 32'd1);

    // Misaligned read still returns the containing word; err remains sticky
    q.push_back('{32'hDEADBEEF, 2});
    xfer(1'b0, 32'h12, 32'h0, 4'h0, 1'b0, 0, 1'b0);
    chk("sticky_err", {31'd0, err0}, 32'd1);
    chk("mis_cnt_rd", cr0, 32'd3);

    // Latency-3 responder RAM preserved across reset
    q.push_back('{32'hCAFEF00D, 5});
    xfer(1'b1, 32'h40, 32'h0, 4'h0, 1'b0, 0, 1'b0);
    chk("keep_err3", {31'd0, err3}, 32'd0);
    chk("keep_cnt_rd3", cr3, 32'd1);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
